fetch_stage: RTL

//   Instruction fetch stage. Holds the PC and reads 16-bit instruction words from

---
 rtl/fetch_stage.sv | 79 +++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with a req/ack memory port, a one-word skid buffer and a redirect flush.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        out_valid
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, KILL} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, pend_q, pend_d, skid_q, skid_d;
  logic [15:0] out_instr_q, out_instr_d, out_pc_q, out_pc_d;
  logic        out_valid_q, out_valid_d, take;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      pend_q      <= RESET_PC;
      skid_q      <= NOP_WORD;
      out_instr_q <= NOP_WORD;
      out_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      skid_q      <= skid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     state_d = redirect ? (imem_ack ? REQ : KILL) : (imem_ack && stall ? HOLD : REQ);
      HOLD:    state_d = (redirect || !stall) ? REQ : HOLD;
      KILL:    state_d = imem_ack ? REQ : KILL;
      default: state_d = IDLE;
    endcase
  end
  // While a request is outstanding, a redirect is parked in pend_q so imem_addr stays stable.
  always_comb begin
    pc_d   = pc_q;
    pend_d = pend_q;
    skid_d = (state_q == REQ && imem_ack) ? imem_data : skid_q;
    if (imem_req && imem_ack)
      pc_d = redirect ? redirect_pc : (state_q == KILL ? pend_q : pc_q + 16'd1);
    else if (imem_req && redirect)
      pend_d = redirect_pc;
    else if (redirect)
      pc_d = redirect_pc;
  end
  // In HOLD pc_q already points past the buffered word, so it doubles as the buffered out_pc.
  always_comb begin
    imem_req    = state_q == REQ || state_q == KILL;
    imem_addr   = pc_q;
    take        = state_q == REQ && imem_ack;
    out_valid_d = redirect ? 1'b0 : stall ? out_valid_q : (state_q == HOLD || take);
    out_instr_d = redirect ? NOP_WORD : stall ? out_instr_q :
                  state_q == HOLD ? skid_q : take ? imem_data : NOP_WORD;
    out_pc_d    = (redirect || stall) ? out_pc_q :
                  state_q == HOLD ? pc_q : take ? pc_q + 16'd1 : out_pc_q;
  end
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_valid = out_valid_q;
endmodule
